cordic_iter_sequencer: RTL and testbench

//  Iteration controller for the hyperbolic CORDIC core of the natural-log unit.
//  It owns the per-iteration shift-amount ROM (LUT_SHIFT, 1-cycle synchronous read with enable).
//  On START it steps the ROM address from 0 to ITERS-1 and registers each returned shift amount.

---
 rtl/cordic_ln_pkg.sv | 11 +
 rtl/cordic_iter_sequencer.sv | 87 ++++++++
 tb/tb_cordic_iter_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cordic_ln_pkg.sv
// cordic_ln_pkg: state encoding and default sizing shared by the natural-log CORDIC blocks
package cordic_ln_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;
    localparam int ITERS_DEF   = 24;
    localparam int ADDR_W_DEF  = 5;
    localparam int SHIFT_W_DEF = 5;
endpackage

// File: rtl/cordic_iter_sequencer.sv
// cordic_iter_sequencer: walks the shift ROM and hands one shift per iteration to the CORDIC datapath
module cordic_iter_sequencer
    import cordic_ln_pkg::*;
#(
    parameter int ITERS   = ITERS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               busy_o,
    output logic               en_rom1_o,
    output logic [ADDR_W-1:0]  adrs_o,
    input  logic [SHIFT_W-1:0] o_d_i,
    output logic [SHIFT_W-1:0] shift_o,
    output logic [ADDR_W-1:0]  iter_idx_o,
    output logic               iter_valid_o,
    input  logic               iter_done_i,
    output logic               first_it_o,
    output logic               done_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ITERS - 1);
    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d, adrs_q, adrs_d, idx_q, idx_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               en_q, en_d, valid_q, valid_d, first_q, first_d, done_q, done_d, busy_q, busy_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:  if (start_i) begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_ISSUE;
            ST_ISSUE: if (iter_done_i) begin
                state_d = (cnt_q == LAST) ? ST_FIN : ST_FETCH;
                cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end
    // outputs are registered: decode from the next state so they line up with it
    assign en_d    = state_d == ST_FETCH;
    assign adrs_d  = en_d ? cnt_d : adrs_q;
    assign shift_d = (state_q == ST_WAIT) ? o_d_i : shift_q;
    assign idx_d   = (state_q == ST_WAIT) ? cnt_q : idx_q;
    assign valid_d = state_d == ST_ISSUE;
    assign first_d = valid_d && cnt_d == '0;
    assign done_d  = state_d == ST_FIN;
    assign busy_d  = state_d != ST_IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adrs_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adrs_q  <= adrs_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            first_q <= first_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
    assign busy_o       = busy_q;
    assign en_rom1_o    = en_q;
    assign adrs_o       = adrs_q;
    assign shift_o      = shift_q;
    assign iter_idx_o   = idx_q;
    assign iter_valid_o = valid_q;
    assign first_it_o   = first_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// tb_cordic_iter_sequencer: random-wait datapath and ROM model around 24- and 32-iteration sequencers
module tb_cordic_iter_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, iter_done = 1'b0, sel = 1'b0;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic       busy24, en24, valid24, first24, done24, busy32, en32, valid32, first32, done32;
    logic [4:0] adrs24, shift24, idx24, adrs32, shift32, idx32;
    logic [4:0] od24 = '0, od32 = '0;
    logic       busy, en, valid, first, done;
    logic [4:0] adrs, shift, idx;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (en24) od24 <= adrs24 ^ 5'h01;
        if (en32) od32 <= adrs32 ^ 5'h01;
    end
    cordic_iter_sequencer #(.ITERS(24), .ADDR_W(5), .SHIFT_W(5)) u24 (
        .clk(clk), .rst_n(rst_n), .start_i(start && !sel), .busy_o(busy24), .en_rom1_o(en24),
        .adrs_o(adrs24), .o_d_i(od24), .shift_o(shift24), .iter_idx_o(idx24), .iter_valid_o(valid24),
        .iter_done_i(iter_done && !sel), .first_it_o(first24), .done_o(done24));
    cordic_iter_sequencer #(.ITERS(32), .ADDR_W(5), .SHIFT_W(5)) u32 (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel), .busy_o(busy32), .en_rom1_o(en32),
        .adrs_o(adrs32), .o_d_i(od32), .shift_o(shift32), .iter_idx_o(idx32), .iter_valid_o(valid32),
        .iter_done_i(iter_done && sel), .first_it_o(first32), .done_o(done32));
    assign busy  = sel ? busy32  : busy24;
    assign en    = sel ? en32    : en24;
    assign valid = sel ? valid32 : valid24;
    assign first = sel ? first32 : first24;
    assign done  = sel ? done32  : done24;
    assign adrs  = sel ? adrs32  : adrs24;
    assign shift = sel ? shift32 : shift24;
    assign idx   = sel ? idx32   : idx24;
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".en"}, en, 0);
        chk({tag, ".adrs"}, adrs, 0);
        chk({tag, ".shift"}, shift, 0);
        chk({tag, ".idx"}, idx, 0);
        chk({tag, ".valid"}, valid, 0);
        chk({tag, ".first"}, first, 0);
        chk({tag, ".done"}, done, 0);
    endtask
    // One run: iteration i's datapath waits w cycles before ITER_DONE; w is random, or fixed for fix_it.
    // abort_it >= 0 resets mid-ISSUE at that iteration; noise wiggles START/ITER_DONE outside ISSUE.
    task automatic do_run(input int n, input bit rnd, input int fix_it, input int fix_w,
                          input int abort_it, input bit noise, input bit hold);
        int t_acc, total;
        start = 1'b1;
        @(negedge clk);
        t_acc = cyc - 1;
        total = 1;
        if (!hold) start = 1'b0;
        for (int i = 0; i < n; i++) begin
            int w;
            w = rnd ? int'($urandom_range(0, 3)) : ((i == fix_it) ? fix_w : 0);
            total += 3 + w;
            chk("fetch.en", en, 1);
            chk("fetch.adrs", adrs, i);
            chk("fetch.valid", valid, 0);
            chk("fetch.busy", busy, 1);
            if (noise) begin start = 1'($urandom); iter_done = 1'($urandom); end
            @(negedge clk);
            chk("wait.en", en, 0);
            chk("wait.valid", valid, 0);
            if (noise) begin start = 1'($urandom); iter_done = 1'($urandom); end
            @(negedge clk);
            if (noise && !hold) start = 1'b0;
            if (i == abort_it) begin
                chk("abort.valid", valid, 1);
                rst_n = 1'b0;
                #1;
                chk_zero("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                iter_done = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    chk("post_rst.done", done, 0);
                    chk("post_rst.busy", busy, 0);
                    @(negedge clk);
                end
                return;
            end
            for (int k = 0; k <= w; k++) begin
                chk("iss.valid", valid, 1);
                chk("iss.shift", shift, i ^ 1);
                chk("iss.idx", idx, i);
                chk("iss.first", first, i == 0);
                chk("iss.done", done, 0);
                if (noise) start = 1'($urandom);
                iter_done = (k == w);
                @(negedge clk);
            end
            iter_done = 1'b0;
            if (noise && !hold) start = 1'b0;
        end
        chk("fin.done", done, 1);
        chk("fin.valid", valid, 0);
        chk("fin.busy", busy, 1);
        chk("fin.cycle", cyc - t_acc, total);
        start = hold;
        @(negedge clk);
        chk("idle.done", done, 0);
        chk("idle.busy", busy, 0);
    endtask
    initial begin
        #1;
        chk_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_run(24, 1'b0, -1, 0, -1, 1'b0, 1'b0);
        do_run(24, 1'b0, 4, 5, -1, 1'b0, 1'b0);
        do_run(24, 1'b0, -1, 0, 7, 1'b0, 1'b0);
        do_run(24, 1'b1, -1, 0, -1, 1'b0, 1'b0);
        do_run(24, 1'b1, -1, 0, -1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            iter_done = 1'($urandom);
            @(negedge clk);
            chk("idle_pulse.valid", valid, 0);
            chk("idle_pulse.done", done, 0);
            chk("idle_pulse.en", en, 0);
            chk("idle_pulse.adrs", adrs, 23);
            chk("idle_pulse.shift", shift, 23 ^ 1);
        end
        iter_done = 1'b0;
        sel = 1'b1;
        @(negedge clk);
        do_run(32, 1'b0, -1, 0, -1, 1'b0, 1'b1);
        do_run(32, 1'b1, -1, 0, -1, 1'b0, 1'b1);
        start = 1'b0;
        @(negedge clk);
        chk("s32.idle_adrs", adrs, 31);
        chk("s32.idle_busy", busy, 0);
        do_run(32, 1'b1, -1, 0, -1, 1'b1, 1'b0);
        sel = 1'b0;
        do_run(24, 1'b1, -1, 0, -1, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
